uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte-stream requesters. Each requester offers message bytes with a `last` marker. A grant is locked to one requester from its first byte until its `last` byte, so messages never interleave on the wire. The block converts the valid/ready requester handshake into the UART's one-cycle `data_in_en` / `data_in_rdy` handshake. It sits between the debug/console producers and the `uart` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `LOCK_TIMEOUT`, 1_000_000, idle cycles of the locked owner before its lock is forcibly released (≥2).
- `clk`  in  1  system clock (81.25 MHz). Single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  N_REQ  requester i offers a byte.
- `req_data`  in  8*N_REQ  byte of requester i at `[8*i+7:8*i]`.
- `req_last`  in  N_REQ  offered byte is the final byte of requester i's message.
- `req_ready`  out  N_REQ  one-hot or zero; byte i transfers on a cycle where `req_valid[i] & req_ready[i]` is true.
- `uart_data`  out  8  drives `uart.data_in`.
- `uart_en`  out  1  drives `uart.data_in_en`; one-cycle pulse.
- `uart_rdy`  in  1  from `uart.data_in_rdy`.
- `grant_id`  out  IDW  current or most recent owner. IDW = max(1, clog2(N_REQ)).
- `locked`  out  1  a multi-byte message is in progress.
- `lock_timeout`  out  1  one-cycle pulse when a lock is forcibly released.

## Operation
- States:
  - INIT (reset state)
  - IDLE
  - ISSUE
  - WAIT_LOW
  - WAIT_HIGH
- INIT → IDLE unconditionally, one cycle after reset release.
- Selection (combinational, IDLE only):
  - If `locked`, candidate = owner.
  - Otherwise, candidate = first i with `req_valid[i]`, scanning from `rr_ptr` upward mod N_REQ.
- `req_ready[cand]` = 1 only when state = IDLE, `uart_rdy` = 1, and a candidate exists. All other `req_ready` bits are 0. `req_ready` is 0 in every other state and during reset.
- On transfer:
  - Capture byte into `uart_data`; set `grant_id` = cand; go to ISSUE.
  - If `req_last` = 0: set `locked` = 1 (owner = cand).
  - If `req_last` = 1: clear `locked` and set `rr_ptr` = (cand+1) mod N_REQ.
- ISSUE: `uart_en` = 1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for `uart_rdy` = 0, then go to WAIT_HIGH.
  - The UART keeps `data_in_rdy` high for one cycle after sampling `data_in_en`. Never re-pulse `uart_en` until the low phase has been seen.
- WAIT_HIGH: wait for `uart_rdy` = 1 (UART stop bit complete), then go to IDLE.
- Lock watchdog:
  - Counter of width clog2(LOCK_TIMEOUT+1).
  - Increments each IDLE cycle where `locked` = 1 and `req_valid[owner]` = 0. Clears on any transfer and whenever unlocked.
  - On reaching LOCK_TIMEOUT: clear `locked`, set `rr_ptr` = owner+1 mod N_REQ, pulse `lock_timeout`, clear the counter. The counter saturates and never wraps.
- Non-owner `req_valid` is ignored while locked, irrespective of priority.
- `rr_ptr` is unchanged by non-final bytes.

## Timing
- Reset values:
  - `uart_en` = 0, `uart_data` = 0, `req_ready` = 0.
  - `grant_id` = 0, `locked` = 0, `lock_timeout` = 0.
  - `rr_ptr` = 0, watchdog = 0, state = INIT.
- Reset asserted mid-message clears everything immediately. Any UART frame already in flight completes on its own; WAIT states are not re-entered.
- Latency: a transfer at edge T gives `uart_en` = 1 and valid `uart_data` in cycle T+1. `uart_data` holds until the next transfer.
- Next transfer is earliest at the first IDLE cycle after `uart_rdy` returns high: roughly one UART frame (10 bit times), plus 3 control cycles.
- `uart_rdy` = 0 already in IDLE: no `req_ready`, no state change.
- `req_last` = 1 on a byte while already locked: ends the message and rotates the pointer.
- Simultaneous watchdog expiry and owner `req_valid` rising in the same cycle: the transfer wins and the counter clears.

## Test plan
- Reset release with `req_valid[2]` = 1, `req_data` = 8'h41, `req_last` = 1, `uart_rdy` = 1:
  - Expect no `req_ready` in the INIT cycle.
  - Expect `req_ready[2]` pulse, `uart_en` one cycle later with `uart_data` = 8'h41, and `grant_id` = 2.
- Requesters 0 and 1 both valid with single-byte messages, UART model looping:
  - Expect grants to alternate 0, 1, 0, 1.
  - Expect exactly one `uart_en` per UART frame, `uart_en` never high for two cycles, and no `req_ready` before `uart_rdy` has dropped and returned high.
- Requester 1 sends 3 bytes (`last` on the third) while requester 3 is continuously valid:
  - Expect bytes 1, 1, 1 on the wire, then requester 3.
  - Expect `locked` = 1 between the first and third byte.
- Requester 0 sends one non-last byte, then drops `req_valid`, with LOCK_TIMEOUT = 16:
  - Expect a `lock_timeout` pulse after 16 idle cycles, `locked` = 0, and requester 1 granted next.
- `rst_n` pulsed low during WAIT_HIGH of a locked message:
  - Expect all outputs to return to reset values asynchronously and arbitration to restart from `rr_ptr` = 0.
- `uart_rdy` held low for 50 cycles with all requesters valid:
  - Expect `req_ready` = 0 and `uart_en` = 0 throughout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream
// requesters; a grant stays locked to its owner until the message's last byte.
module uart_tx_arbiter #(
    parameter int  N_REQ        = 4,
    parameter int  LOCK_TIMEOUT = 1_000_000,
    localparam int IDW          = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         uart_data,
    output logic               uart_en,
    input  logic               uart_rdy,
    output logic [IDW-1:0]     grant_id,
    output logic               locked,
    output logic               lock_timeout
);

    localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [WD_W-1:0] wd_cnt;
    logic [IDW-1:0]  cand;
    logic            cand_ok;
    logic            xfer;
    logic [7:0]      sel_data;
    logic            sel_last;

    function automatic logic [IDW-1:0] rr_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    // Candidate selection: the owner while locked, else first valid from rr_ptr.
    always_comb begin
        cand    = grant_id;
        cand_ok = 1'b0;
        if (locked) begin
            cand_ok = req_valid[grant_id];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req_valid[rr_add(rr_ptr, k)]) begin
                    cand    = rr_add(rr_ptr, k);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    assign xfer     = (state == S_IDLE) && uart_rdy && cand_ok;
    assign sel_data = req_data[8*int'(cand) +: 8];
    assign sel_last = req_last[cand];

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[cand] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            uart_en      <= 1'b0;
            uart_data    <= 8'h00;
            grant_id     <= '0;
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
            rr_ptr       <= '0;
            wd_cnt       <= '0;
        end else begin
            uart_en      <= 1'b0;
            lock_timeout <= 1'b0;
            case (state)
                S_INIT: state <= S_IDLE;
                S_IDLE: begin
                    if (xfer) begin
                        uart_data <= sel_data;
                        grant_id  <= cand;
                        uart_en   <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= S_ISSUE;
                        if (sel_last) begin
                            locked <= 1'b0;
                            rr_ptr <= rr_add(cand, 1);
                        end else begin
                            locked <= 1'b1;
                        end
                    end else if (locked && !req_valid[grant_id]) begin
                        // The expiring idle cycle releases directly, so the count never exceeds WD_LAST.
                        if (wd_cnt == WD_LAST) begin
                            locked       <= 1'b0;
                            rr_ptr       <= rr_add(grant_id, 1);
                            lock_timeout <= 1'b1;
                            wd_cnt       <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end else if (!locked) begin
                        wd_cnt <= '0;
                    end
                end
                S_ISSUE: state <= S_WAIT_LOW;
                // The UART holds data_in_rdy high one cycle after sampling; wait for its low phase.
                S_WAIT_LOW: begin
                    if (!uart_rdy) state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (uart_rdy) state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reactive UART model, per-requester byte queues,
// and a cycle-level reference model compared on every negative clock edge.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_data;
    logic           uart_en;
    logic           uart_rdy;
    logic [1:0]     grant_id;
    logic           locked;
    logic           lock_timeout;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .uart_data(uart_data), .uart_en(uart_en), .uart_rdy(uart_rdy),
        .grant_id(grant_id), .locked(locked), .lock_timeout(lock_timeout)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester byte queues (ring buffers)
    logic [7:0] buf_d [N][256];
    logic       buf_l [N][256];
    int         head  [N];
    int         tail  [N];

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = buf_d[i][head[i] % 256];
                req_last[i]        = buf_l[i][head[i] % 256];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        buf_d[r][tail[r] % 256] = d;
        buf_l[r][tail[r] % 256] = l;
        tail[r]++;
        drive_reqs();
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Requester side: pop a byte after each accepted handshake
    initial begin
        logic [N-1:0] hs;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (rst_n) for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
            drive_reqs();
        end
    end

    // UART model: rdy high one cycle after sampling en, then low for a frame
    logic hold_low = 1'b0;
    int   ustage   = 0;
    initial begin
        logic en_s;
        int   low_left;
        int   frame_len;
        frame_len = 3;
        low_left  = 0;
        uart_rdy  = 1'b1;
        forever begin
            @(negedge clk);
            en_s = uart_en;
            @(posedge clk);
            #1;
            if (ustage == 0) begin
                uart_rdy = !hold_low;
                if (en_s === 1'b1) ustage = 1;
            end else if (ustage == 1) begin
                uart_rdy = 1'b0;
                low_left = frame_len;
                ustage   = 2;
            end else begin
                low_left--;
                if (low_left == 0) begin
                    uart_rdy  = !hold_low;
                    ustage    = 0;
                    frame_len = $urandom_range(2, 6);
                end
            end
        end
    end

    // Reference model. Phases: waiting one cycle after reset, available for a byte,
    // pulsing the UART, waiting for the UART busy phase to begin, waiting for it to end.
    localparam int P_INIT = 0, P_AVAIL = 1, P_PULSE = 2, P_BUSYWAIT = 3, P_FRAME = 4;
    int         m_ph, n_ph;
    logic [7:0] m_data, n_data;
    logic [1:0] m_gid, n_gid, m_ptr, n_ptr;
    logic       m_lock, n_lock, m_to, n_to;
    int         m_idle, n_idle;
    logic [1:0] log_q [$];

    task automatic model_reset();
        m_ph = P_INIT; m_data = 8'h00; m_gid = 2'd0; m_ptr = 2'd0;
        m_lock = 1'b0; m_to = 1'b0; m_idle = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                m_ph = n_ph; m_data = n_data; m_gid = n_gid; m_ptr = n_ptr;
                m_lock = n_lock; m_to = n_to; m_idle = n_idle;
            end
        end
    end

    initial begin
        logic [N-1:0] e_rdy;
        logic [1:0]   cand;
        bit           have;
        int           idx;
        forever begin
            @(negedge clk);
            have = 1'b0; cand = 2'd0; e_rdy = '0;
            if (m_ph == P_AVAIL && uart_rdy) begin
                if (m_lock) begin
                    if (req_valid[m_gid]) begin have = 1'b1; cand = m_gid; end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        idx = (int'(m_ptr) + k) % N;
                        if (!have && req_valid[idx]) begin have = 1'b1; cand = idx[1:0]; end
                    end
                end
                if (have) e_rdy[cand] = 1'b1;
            end
            chk("req_ready", req_ready, e_rdy);
            chk("uart_en", uart_en, (m_ph == P_PULSE));
            chk("uart_data", uart_data, m_data);
            chk("grant_id", grant_id, m_gid);
            chk("locked", locked, m_lock);
            chk("lock_timeout", lock_timeout, m_to);
            if (rst_n && uart_en) log_q.push_back(grant_id);

            n_ph = m_ph; n_data = m_data; n_gid = m_gid; n_ptr = m_ptr;
            n_lock = m_lock; n_to = 1'b0; n_idle = m_idle;
            case (m_ph)
                P_INIT: n_ph = P_AVAIL;
                P_AVAIL: begin
                    if (have) begin
                        n_data = req_data[8*cand +: 8];
                        n_gid  = cand;
                        n_ph   = P_PULSE;
                        n_idle = 0;
                        if (req_last[cand]) begin
                            n_lock = 1'b0;
                            n_ptr  = 2'((int'(cand) + 1) % N);
                        end else n_lock = 1'b1;
                    end else if (m_lock && !req_valid[m_gid]) begin
                        n_idle = m_idle + 1;
                        if (n_idle == TO) begin
                            n_lock = 1'b0;
                            n_ptr  = 2'((int'(m_gid) + 1) % N);
                            n_to   = 1'b1;
                            n_idle = 0;
                        end
                    end
                end
                P_PULSE:    n_ph = P_BUSYWAIT;
                P_BUSYWAIT: if (!uart_rdy) n_ph = P_FRAME;
                default:    if (uart_rdy) n_ph = P_AVAIL;
            endcase
        end
    end

    function automatic int log_at(input int i);
        if (i < log_q.size()) return int'(log_q[i]);
        return 99;
    endfunction

    task automatic wait_log(input int n, input string nm);
        int b;
        b = 0;
        while (log_q.size() < n && b < 3000) begin @(negedge clk); b++; end
        chk(nm, (log_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input string nm);
        int b, q;
        b = 0; q = 0;
        while (q < 4 && b < 20000) begin
            @(negedge clk);
            b++;
            if (queues_empty() && ustage == 0 && !uart_en && uart_rdy) q++;
            else q = 0;
        end
        chk(nm, (q >= 4), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        for (int i = 0; i < N; i++) head[i] = tail[i];
        drive_reqs();
        log_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int  r, len, b;
        bit  inc, seen;
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

        // Reset release with requester 2 holding a single-byte message
        push_byte(2, 8'h41, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); chk("t1_init_ready", req_ready, 4'b0000);
        @(negedge clk); chk("t1_ready2", req_ready, 4'b0100);
        @(negedge clk);
        chk("t1_en", uart_en, 1);
        chk("t1_data", uart_data, 8'h41);
        chk("t1_gid", grant_id, 2);
        wait_idle("t1_idle");

        // Two requesters with single-byte messages alternate
        do_reset();
        push_byte(0, 8'hA0, 1'b1); push_byte(0, 8'hA1, 1'b1);
        push_byte(1, 8'hB0, 1'b1); push_byte(1, 8'hB1, 1'b1);
        wait_log(4, "t2_log4");
        chk("t2_g0", log_at(0), 0); chk("t2_g1", log_at(1), 1);
        chk("t2_g2", log_at(2), 0); chk("t2_g3", log_at(3), 1);
        wait_idle("t2_idle");

        // Locked 3-byte message from requester 1 while requester 3 waits
        do_reset();
        push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h12, 1'b0); push_byte(1, 8'h13, 1'b1);
        push_byte(3, 8'h31, 1'b1); push_byte(3, 8'h32, 1'b1);
        wait_log(2, "t3_log2");
        chk("t3_locked_mid", locked, 1);
        wait_log(4, "t3_log4");
        chk("t3_g0", log_at(0), 1); chk("t3_g1", log_at(1), 1);
        chk("t3_g2", log_at(2), 1); chk("t3_g3", log_at(3), 3);
        wait_idle("t3_idle");

        // Owner stalls mid-message; watchdog releases and requester 1 follows
        do_reset();
        push_byte(0, 8'h10, 1'b0);
        push_byte(1, 8'h20, 1'b1);
        b = 0; seen = 1'b0;
        while (!seen && b < 500) begin
            @(negedge clk);
            b++;
            if (lock_timeout) begin seen = 1'b1; chk("t4_locked_after", locked, 0); end
        end
        chk("t4_timeout_seen", seen, 1);
        wait_log(2, "t4_log2");
        chk("t4_first", log_at(0), 0);
        chk("t4_second", log_at(1), 1);
        wait_idle("t4_idle");

        // Reset during a frame of a locked message
        do_reset();
        push_byte(2, 8'h30, 1'b0);
        wait_log(1, "t5_log1");
        push_byte(1, 8'h40, 1'b1);
        push_byte(2, 8'h31, 1'b1);
        b = 0;
        while (uart_rdy && b < 100) begin @(negedge clk); b++; end
        chk("t5_frame_started", uart_rdy, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", req_ready, 0); chk("t5_rst_en", uart_en, 0);
        chk("t5_rst_data", uart_data, 0);  chk("t5_rst_gid", grant_id, 0);
        chk("t5_rst_locked", locked, 0);   chk("t5_rst_to", lock_timeout, 0);
        log_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_log(2, "t5_log2");
        chk("t5_first", log_at(0), 1);
        chk("t5_second", log_at(1), 2);
        wait_idle("t5_idle");

        // UART not ready for 50 cycles with every requester valid
        @(posedge clk); #2 hold_low = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) push_byte(i, 8'(8'h50 + i), 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("t6_ready", req_ready, 0);
            chk("t6_en", uart_en, 0);
        end
        @(posedge clk); #2 hold_low = 1'b0;
        wait_idle("t6_idle");

        // Randomized traffic, including occasional unterminated messages
        do_reset();
        for (int it = 0; it < 250; it++) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            inc = ($urandom_range(0, 7) == 0);
            if (tail[r] - head[r] < 200)
                for (int j = 0; j < len; j++)
                    push_byte(r, 8'($urandom), (j == len - 1) && !inc);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        wait_idle("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
